// File: rtl/fetch_ctrl_if.sv
// Fetch-side signal bundle: ROM port, decode handshake, redirect/halt control
// and PC observation. Optional FETCH_CNT_EN adds the fetch_cnt observation bus.
// master = fetch_ctrl side, slave = ROM/decode/execute environment side.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              rom_en;
    logic [ADDR_W-3:0] rom_addr;
    logic [31:0]       rom_dout;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
`ifdef FETCH_CNT_EN
    logic [31:0]       fetch_cnt;

    modport master (
        output rom_en, rom_addr, instr, instr_pc, instr_valid, pc, pc_plus4, fetch_cnt,
        input  rom_dout, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  rom_en, rom_addr, instr, instr_pc, instr_valid, pc, pc_plus4, fetch_cnt,
        output rom_dout, instr_ready, redirect, redirect_pc, halt
    );
`else
    modport master (
        output rom_en, rom_addr, instr, instr_pc, instr_valid, pc, pc_plus4,
        input  rom_dout, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  rom_en, rom_addr, instr, instr_pc, instr_valid, pc, pc_plus4,
        output rom_dout, instr_ready, redirect, redirect_pc, halt
    );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, reads a synchronous
// word-addressed ROM with ROM_LAT clocks of latency and hands each word to
// decode over valid/ready. Redirects (highest priority) and halts are applied
// between fetches. Optional macro FETCH_CNT_EN adds a saturating count of
// completed decode handshakes on fetch_cnt.
module fetch_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter int          ROM_LAT  = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clka,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_VALID  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam int              LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [ADDR_W-1:0] RST_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_handshake;
    logic              w_unused_bits;

    // PC arithmetic wraps naturally at ADDR_W bits; redirect target is word aligned
    assign w_pc_plus4    = r_pc + ADDR_W'(4);
    assign w_redirect_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_handshake   = r_instr_valid & bus.instr_ready;
    assign w_unused_bits = ^{bus.redirect_pc[31:ADDR_W], bus.redirect_pc[1:0]};

    // Reset parks the FSM in REQ, but the ROM must not be enabled while reset is held
    assign bus.rom_en      = (r_state == S_REQ) & ~rst;
    assign bus.rom_addr    = r_pc[ADDR_W-1:2];
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = 32'(r_instr_pc);
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = 32'(r_pc);
    assign bus.pc_plus4    = 32'(w_pc_plus4);

    // Fetch sequencer: request, wait out ROM latency, present to decode, optional halt
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RST_PC;
            r_lat_cnt     <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (bus.redirect) begin
            // Any in-flight ROM word is dropped by returning to REQ; a halted
            // front end only picks up the new PC and stays halted.
            r_pc          <= w_redirect_pc;
            r_instr_valid <= 1'b0;
            r_lat_cnt     <= '0;
            if (r_state != S_HALTED) begin
                r_state <= S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_state   <= S_WAIT;
                        r_lat_cnt <= LAT_W'(ROM_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end else begin
                        r_instr       <= bus.rom_dout;
                        r_instr_pc    <= r_pc;
                        r_pc          <= w_pc_plus4;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= bus.halt ? S_HALTED : S_REQ;
                    end
                end
                S_HALTED: begin
                    if (!bus.halt) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    assign bus.fetch_cnt = r_fetch_cnt;

    // Saturating count of decode handshakes; a redirect in the same cycle still counts
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (w_handshake && (r_fetch_cnt != '1)) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end
`else
    logic w_unused_handshake;

    assign w_unused_handshake = w_handshake;
`endif

endmodule
